fft_frame_buffer: RTL and testbench
===================================

# fft_frame_buffer

Collects a stream of real audio samples into N-sample frames and hands each complete frame to the `fft` core with a start/done handshake. The block sits directly upstream of `fft`. It drives that core's `samples`, `start` and `reset`-aligned inputs, and consumes its `done`. Storage is ping-pong: one bank fills from the stream while the other is held stable for the FFT.

## Interface
- `N`, 4: samples per frame; must match the `fft` point count.
- `SAMPLE_W`, 16: real sample width. Each complex word is `2*SAMPLE_W` bits wide.

- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high. Shared with `fft`.
- `in_sample`  in  SAMPLE_W: signed real sample.
- `in_valid`  in  1: `in_sample` is valid.
- `in_ready`  out  1: a sample is accepted on any edge where `in_valid && in_ready`.
- `fft_samples[0:N-1]`  out  2*SAMPLE_W each: the frame presented to `fft`.
- `fft_start`  out  1: level request to `fft`.
- `fft_done`  in  1: `fft` completion.
- `frame_count`  out  16: number of frames issued; wraps.

## Operation
- **Packing.** Each complex word is {`in_sample`, SAMPLE_W'0}: real in the upper half, imaginary zero. The first accepted sample of a frame goes to index 0.
- **Fill side.**
  - `fill_idx` counts 0..N-1.
  - Accepting the sample at index N-1 sets `fill_full` and resets `fill_idx` to 0.
  - `in_ready = !fill_full` (combinational from a register).
  - `in_sample` is ignored whenever `in_valid` is low.
- **Output FSM, two states:**
  - IDLE: `fft_start` = 0. If `fill_full`, swap on this edge:
    - the fill bank becomes the output bank;
    - `fill_full` is cleared;
    - `fft_start` is set to 1;
    - `frame_count` increments;
    - next state is BUSY.
  - BUSY: `fft_start` = 1. `fft_done` sampled high → IDLE and `fft_start` = 0. Otherwise remain in BUSY.
- **`fft_done` outside BUSY** is ignored.
- **Back-pressure.** While the output is BUSY, the fill side may complete a second frame. After that, `in_ready` stays low until the swap. No samples are ever dropped.
- **Stable output.** `fft_samples` changes only on a swap edge. It is constant from a swap until the next swap.
- **Reset.** All of the following are cleared:
  - `fill_idx`, `fill_full`, FSM (to IDLE), `fft_start`, all `fft_samples` words, `frame_count`.
  - Samples presented during reset are not accepted.
  - A reset mid-fill or mid-FFT discards the partial or pending frame.

## Timing
- **Reset values:** `in_ready` = 1 on the first cycle after reset deasserts, `fft_start` = 0, `fft_samples` = 0, `frame_count` = 0.
- **Accept-to-start latency.** The last sample of a frame is accepted at edge E. If the FSM is IDLE, the swap happens at E+1, where `fft_start` rises and `fft_samples` update.
  - `in_ready` is low for exactly one cycle, between E and E+1. That is one bubble per frame.
- **Start/done spacing.** `fft_done` is sampled high at edge D. `fft_start` falls at D. The earliest next rise is D+1, so `fft_start` is low for at least one cycle between frames.
- **Simultaneous events.** At one edge the last sample may be accepted while `fft_done` returns BUSY to IDLE. The swap then occurs on the next edge, after both registered updates.
- **`frame_count`** increments on the swap edge. Wrap 0xFFFF → 0x0000 is legal.

## Structure
- **Shared package `fft_pkg`:**
  - `N`, `SAMPLE_W`;
  - `typedef logic signed [2*SAMPLE_W-1:0] cplx_t`;
  - the packing helper function (real into upper half, imaginary zero).
  - `fft` uses the same package.
- **Sub-module `fft_sample_bank`:** N-entry `cplx_t` register file with write enable, write index and clear. It is instantiated twice. A bank-select bit chooses the fill bank and the output bank.
- The FSM and fill counter live in the top level.

## Test plan
- **Basic frame.**
  - Stimulus: reset, then stream 100, 150, 200, 250 with `in_valid` held high.
  - Response: `fft_start` rises one cycle after the 4th accept. `fft_samples` = 0x0064_0000, 0x0096_0000, 0x00C8_0000, 0x00FA_0000. `frame_count` = 1.
- **Handshake.**
  - Hold `fft_done` low for 5 cycles → `fft_start` stays high and `fft_samples` is stable.
  - Pulse `fft_done` → `fft_start` falls at that edge.
- **Back-pressure.**
  - Stimulus: stream 8 samples (15, 66, 128, 52, 1, 2, 3, 4) while `fft_done` is held low.
  - Response: `in_ready` drops after the 8th accept. `fft_samples` still shows the 15/66/128/52 frame.
  - Then pulse `fft_done` → one cycle low on `fft_start`, then it rises again with the 1/2/3/4 frame.
- **Simultaneous events.**
  - Stimulus: accept the last sample of frame 2 on the same edge `fft_done` is high.
  - Response: the swap occurs exactly one edge later and `fft_start` is low for exactly one cycle.
- **Reset mid-operation.**
  - Assert reset after 2 samples of a frame and while BUSY.
  - Response: all outputs return to their reset values. The next 4 samples form a clean frame with index 0 = the first sample after reset.
- **`in_valid` gaps and stray done.**
  - Random gaps in `in_valid` give the same frame contents as a gapless stream.
  - `fft_done` pulsed while IDLE has no effect.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end and the fft core: frame size,
// sample width, complex word type and the real-to-complex packing helper.
package fft_pkg;

  localparam int unsigned N        = 4;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;

  typedef logic signed [SAMPLE_W-1:0]   sample_t;
  typedef logic signed [2*SAMPLE_W-1:0] cplx_t;

  typedef enum logic {
    StIdle,
    StBusy
  } out_state_e;

  // Real part in the upper half, imaginary part zero.
  function automatic cplx_t pack_real(input sample_t s);
    return {s, {SAMPLE_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// N-entry complex register file. Clear has priority over a write.
module fft_sample_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  cplx_t            wr_data,
  output cplx_t            words [0:N-1]
);

  cplx_t mem_q [0:N-1];

  // Storage: synchronous clear of every entry, otherwise single-entry write.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Expose the register contents directly.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      words[i] = mem_q[i];
    end
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame collector in front of the fft core. One bank fills from the
// sample stream while the other is held stable on fft_samples until the core
// signals done and the next full frame is swapped in.
module fft_frame_buffer
  import fft_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  output cplx_t                      fft_samples [0:N-1],
  output logic                       fft_start,
  input  logic                       fft_done,
  output logic [15:0]                frame_count
);

  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic             fill_full_q, fill_full_d;
  // bank_sel_q names the bank currently filling; the other one is on the output.
  logic             bank_sel_q, bank_sel_d;
  out_state_e       state_q, state_d;
  logic [15:0]      frame_count_q, frame_count_d;

  logic  accept;
  logic  swap;
  cplx_t wr_word;
  cplx_t bank0_words [0:N-1];
  cplx_t bank1_words [0:N-1];

  assign in_ready    = !fill_full_q;
  assign accept      = in_valid && !fill_full_q && !reset;
  assign swap        = (state_q == StIdle) && fill_full_q;
  assign wr_word     = pack_real(in_sample);
  assign fft_start   = (state_q == StBusy);
  assign frame_count = frame_count_q;

  fft_sample_bank u_bank0 (
    .clk     (clk),
    .clear   (reset),
    .wr_en   (accept && !bank_sel_q),
    .wr_idx  (fill_idx_q),
    .wr_data (wr_word),
    .words   (bank0_words)
  );

  fft_sample_bank u_bank1 (
    .clk     (clk),
    .clear   (reset),
    .wr_en   (accept && bank_sel_q),
    .wr_idx  (fill_idx_q),
    .wr_data (wr_word),
    .words   (bank1_words)
  );

  // Output mux: present the bank that is not filling.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      fft_samples[i] = bank_sel_q ? bank0_words[i] : bank1_words[i];
    end
  end

  // Fill-side next state: advance the index per accepted sample, flag a full
  // frame on the last index, release the flag when the frame is swapped out.
  always_comb begin
    fill_idx_d  = fill_idx_q;
    fill_full_d = fill_full_q;
    if (accept) begin
      if (fill_idx_q == IDX_W'(N - 1)) begin
        fill_full_d = 1'b1;
        fill_idx_d  = '0;
      end else begin
        fill_idx_d = fill_idx_q + 1'b1;
      end
    end
    if (swap) begin
      fill_full_d = 1'b0;
    end
  end

  // Output FSM next state: swap banks when a full frame waits in IDLE, hold
  // BUSY until the core reports done.
  always_comb begin
    state_d       = state_q;
    bank_sel_d    = bank_sel_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      StIdle: begin
        if (fill_full_q) begin
          bank_sel_d    = !bank_sel_q;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = StBusy;
        end
      end
      StBusy: begin
        if (fft_done) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_idx_q    <= '0;
      fill_full_q   <= 1'b0;
      bank_sel_q    <= 1'b0;
      state_q       <= StIdle;
      frame_count_q <= '0;
    end else begin
      fill_idx_q    <= fill_idx_d;
      fill_full_q   <= fill_full_d;
      bank_sel_q    <= bank_sel_d;
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer with a frame-level reference model
// checked on every cycle plus literal expectations at key points.
module tb_fft_frame_buffer;
  import fft_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic signed [SAMPLE_W-1:0] in_sample = '0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  cplx_t                      fft_samples [0:N-1];
  logic                       fft_start;
  logic                       fft_done = 1'b0;
  logic [15:0]                frame_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fft_frame_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fft_samples (fft_samples),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .frame_count (frame_count)
  );

  // Reference model: accepted samples collect in a queue; a completed frame
  // waits as "pending" until the output is free, then becomes the output frame.
  logic signed [SAMPLE_W-1:0] m_partial [$];
  cplx_t       m_pend [N];
  bit          m_has_pend;
  cplx_t       m_out [N];
  bit          m_busy;
  logic [15:0] m_count;
  bit          m_accepted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input logic signed [SAMPLE_W-1:0] s,
                            input bit done);
    bit acc;
    bit sw;
    if (rst) begin
      m_partial.delete();
      m_has_pend = 0;
      m_busy     = 0;
      m_count    = '0;
      m_accepted = 0;
      for (int i = 0; i < N; i++) begin
        m_out[i]  = '0;
        m_pend[i] = '0;
      end
      return;
    end
    acc = v && !m_has_pend;
    sw  = !m_busy && m_has_pend;
    if (sw) begin
      m_out      = m_pend;
      m_has_pend = 0;
      m_busy     = 1;
      m_count    = m_count + 16'd1;
    end else if (m_busy && done) begin
      m_busy = 0;
    end
    if (acc) begin
      m_partial.push_back(s);
      if (m_partial.size() == N) begin
        for (int i = 0; i < N; i++) begin
          m_pend[i] = cplx_t'(m_partial[i]) * 65536;
        end
        m_has_pend = 1;
        m_partial.delete();
      end
    end
    m_accepted = acc;
  endtask

  task automatic compare_all();
    chk("in_ready", {31'b0, in_ready}, {31'b0, !m_has_pend});
    chk("fft_start", {31'b0, fft_start}, {31'b0, m_busy});
    chk("frame_count", {16'b0, frame_count}, {16'b0, m_count});
    for (int i = 0; i < N; i++) begin
      chk($sformatf("fft_samples[%0d]", i), fft_samples[i], m_out[i]);
    end
  endtask

  // One clock: drive inputs after the falling edge, update the model at the
  // rising edge, compare on the next falling edge.
  task automatic step(input bit rst, input bit v, input logic signed [SAMPLE_W-1:0] s,
                      input bit done);
    reset     = rst;
    in_valid  = v;
    in_sample = s;
    fft_done  = done;
    @(posedge clk);
    model_edge(rst, v, s, done);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0);
  endtask

  task automatic send(input logic signed [SAMPLE_W-1:0] s, input bit done);
    for (int t = 0; t < 20; t++) begin
      step(0, 1, s, done);
      if (m_accepted) return;
    end
    miscompares++;
    $display("FAIL send_timeout: sample %0d never accepted", s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    step(1, 0, '0, 0);
    step(1, 1, 16'sd77, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_fft_start", {31'b0, fft_start}, 32'd0);
    chk("rst_count", {16'b0, frame_count}, 32'd0);
    chk("rst_word0", fft_samples[0], 32'h0000_0000);

    // Basic frame
    send(16'sd100, 0);
    send(16'sd150, 0);
    send(16'sd200, 0);
    send(16'sd250, 0);
    chk("basic_bubble_ready", {31'b0, in_ready}, 32'd0);
    chk("basic_start_not_yet", {31'b0, fft_start}, 32'd0);
    idle(1);
    chk("basic_start", {31'b0, fft_start}, 32'd1);
    chk("basic_w0", fft_samples[0], 32'h0064_0000);
    chk("basic_w1", fft_samples[1], 32'h0096_0000);
    chk("basic_w2", fft_samples[2], 32'h00C8_0000);
    chk("basic_w3", fft_samples[3], 32'h00FA_0000);
    chk("basic_count", {16'b0, frame_count}, 32'd1);
    chk("model_basic_w3", m_out[3], 32'h00FA_0000);

    // Handshake
    idle(5);
    chk("hold_start", {31'b0, fft_start}, 32'd1);
    chk("hold_w0", fft_samples[0], 32'h0064_0000);
    step(0, 0, '0, 1);
    chk("done_start_fall", {31'b0, fft_start}, 32'd0);

    // Back-pressure
    send(16'sd15, 0);
    send(16'sd66, 0);
    send(16'sd128, 0);
    send(16'sd52, 0);
    send(16'sd1, 0);
    send(16'sd2, 0);
    send(16'sd3, 0);
    send(16'sd4, 0);
    chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
    chk("bp_w0", fft_samples[0], 32'h000F_0000);
    chk("bp_w3", fft_samples[3], 32'h0034_0000);
    chk("bp_count", {16'b0, frame_count}, 32'd2);
    step(0, 1, 16'sd99, 0);
    step(0, 1, 16'sd99, 0);
    chk("bp_still_low", {31'b0, in_ready}, 32'd0);
    step(0, 0, '0, 1);
    chk("bp_gap_start", {31'b0, fft_start}, 32'd0);
    chk("bp_gap_w1", fft_samples[1], 32'h0042_0000);
    idle(1);
    chk("bp_restart", {31'b0, fft_start}, 32'd1);
    chk("bp_w0b", fft_samples[0], 32'h0001_0000);
    chk("bp_w3b", fft_samples[3], 32'h0004_0000);
    chk("bp_count3", {16'b0, frame_count}, 32'd3);

    // Simultaneous last-accept and done
    send(16'sd10, 0);
    send(16'sd20, 0);
    send(16'sd30, 0);
    send(16'sd40, 1);
    chk("sim_start_low", {31'b0, fft_start}, 32'd0);
    chk("sim_ready_low", {31'b0, in_ready}, 32'd0);
    idle(1);
    chk("sim_start_high", {31'b0, fft_start}, 32'd1);
    chk("sim_count", {16'b0, frame_count}, 32'd4);
    chk("sim_w0", fft_samples[0], 32'h000A_0000);

    // Reset mid-fill and mid-FFT
    send(16'sd5, 0);
    send(16'sd6, 0);
    step(1, 1, 16'sd999, 0);
    chk("mrst_count", {16'b0, frame_count}, 32'd0);
    chk("mrst_start", {31'b0, fft_start}, 32'd0);
    chk("mrst_w0", fft_samples[0], 32'h0000_0000);
    chk("mrst_w2", fft_samples[2], 32'h0000_0000);
    chk("mrst_ready", {31'b0, in_ready}, 32'd1);

    // Gapped stream after reset
    idle($urandom_range(0, 2));
    send(16'sd7, 0);
    idle($urandom_range(0, 3));
    send(16'sd8, 0);
    idle($urandom_range(0, 3));
    send(16'sd9, 0);
    idle($urandom_range(0, 3));
    send(16'sd10, 0);
    idle(1);
    chk("gap_w0", fft_samples[0], 32'h0007_0000);
    chk("gap_w1", fft_samples[1], 32'h0008_0000);
    chk("gap_w3", fft_samples[3], 32'h000A_0000);
    chk("gap_count", {16'b0, frame_count}, 32'd1);

    // Stray done while idle
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    chk("stray_start", {31'b0, fft_start}, 32'd0);
    chk("stray_count", {16'b0, frame_count}, 32'd1);

    // Sign and extreme values
    send(-16'sd3, 0);
    send(16'sd4096, 0);
    send(-16'sd32768, 0);
    send(16'sd32767, 0);
    idle(1);
    chk("sign_w0", fft_samples[0], 32'hFFFD_0000);
    chk("sign_w1", fft_samples[1], 32'h1000_0000);
    chk("sign_w2", fft_samples[2], 32'h8000_0000);
    chk("sign_w3", fft_samples[3], 32'h7FFF_0000);
    chk("model_sign_w2", m_out[2], 32'h8000_0000);
    chk("sign_count", {16'b0, frame_count}, 32'd2);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
